hub75_rx: RTL and testbench

HUB75 panel-side receiver for the 32x32 LED matrix. It samples the `R0..B1`, `LED_CLK`, `STB`, `OE` and `sel_ABCD` outputs of `led_matrix` the way the physical panel does. It rebuilds the displayed frame in an internal 32x32x3-bit image that can be read through a random-access port. It sits beside `led_matrix` in simulation and in on-chip debug builds, and checks drive timing, row addressing and shift length.

---
 rtl/hub75_rx.sv | 163 ++++++++++++++++
 tb/tb_hub75_rx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
// hub75_rx: panel-side HUB75 receiver. It samples the led_matrix drive pins the
// same way a physical panel does and rebuilds the shown frame in a 32x32x3
// image with a registered random-access read port. It also reports shift
// length errors, latch events and frame completion.
module hub75_rx #(
    parameter int COLS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       R0,
    input  logic       G0,
    input  logic       B0,
    input  logic       R1,
    input  logic       G1,
    input  logic       B1,
    input  logic       LED_CLK,
    input  logic       STB,
    input  logic       OE,
    input  logic [3:0] sel_ABCD,
    input  logic [4:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [2:0] rd_rgb,
    output logic       row_latched,
    output logic [3:0] latched_sel,
    output logic       frame_done,
    output logic       len_err,
    output logic       oe_active
);
    localparam int SW       = 13;   // bundled pin width through the synchronizer
    localparam int ROWS     = 32;
    localparam int IMG_COLS = 32;

    typedef logic [COLS-1:0][2:0]     shreg_t;
    typedef logic [IMG_COLS-1:0][2:0] imgrow_t;
    typedef logic [ROWS-1:0][IMG_COLS-1:0][2:0] image_t;

    // Map a shift register onto one image row; columns beyond COLS read as 0.
    function automatic imgrow_t to_row(input shreg_t s);
        logic [COLS+IMG_COLS-1:0][2:0] wide;
        wide             = '0;
        wide[COLS-1:0]   = s;
        return wide[IMG_COLS-1:0];
    endfunction

    // OE is carried inverted so the cleared synchronizer means "panel dark".
    logic [SW-1:0] pins;
    assign pins = {R0, G0, B0, R1, G1, B1, LED_CLK, STB, ~OE, sel_ABCD};

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic          stb_prev_q, stb_prev_d;
    shreg_t        up_sr_q, up_sr_d;
    shreg_t        lo_sr_q, lo_sr_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]    cnt_inc;
    image_t        image_q, image_d;
    logic [2:0]    rd_rgb_q, rd_rgb_d;
    logic          row_latched_q, row_latched_d;
    logic [3:0]    latched_sel_q, latched_sel_d;
    logic          frame_done_q, frame_done_d;
    logic          len_err_q, len_err_d;

    // Fields of the last synchronizer stage; everything acts on these.
    logic [SW-1:0] s_last;
    logic [2:0]    s_up, s_lo;
    logic          s_clk, s_stb, s_oe_on;
    logic [3:0]    s_sel;
    logic          led_rise, stb_rise;

    assign s_last  = sync_q[SYNC_STAGES-1];
    assign s_up    = s_last[12:10];
    assign s_lo    = s_last[9:7];
    assign s_clk   = s_last[6];
    assign s_stb   = s_last[5];
    assign s_oe_on = s_last[4];
    assign s_sel   = s_last[3:0];

    assign led_rise = s_clk & ~clk_prev_q;
    assign stb_rise = s_stb & ~stb_prev_q;

    // Synchronizer chain: stage 0 takes the pins, each later stage the one before.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Shift, latch and read-port next-state; a coincident shift lands before the latch.
    always_comb begin
        clk_prev_d    = s_clk;
        stb_prev_d    = s_stb;
        up_sr_d       = up_sr_q;
        lo_sr_d       = lo_sr_q;
        bit_cnt_d     = bit_cnt_q;
        image_d       = image_q;
        row_latched_d = 1'b0;
        len_err_d     = 1'b0;
        frame_done_d  = 1'b0;
        latched_sel_d = latched_sel_q;
        cnt_inc       = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;

        if (led_rise) begin
            up_sr_d   = {up_sr_q[COLS-2:0], s_up};
            lo_sr_d   = {lo_sr_q[COLS-2:0], s_lo};
            bit_cnt_d = cnt_inc;
        end

        if (stb_rise) begin
            image_d[{1'b0, s_sel}] = to_row(up_sr_d);
            image_d[{1'b1, s_sel}] = to_row(lo_sr_d);
            row_latched_d          = 1'b1;
            latched_sel_d          = s_sel;
            len_err_d              = (bit_cnt_d != 6'(COLS));
            frame_done_d           = (s_sel == 4'hF);
            bit_cnt_d              = 6'd0;
        end

        // Reads see the image before any write in this cycle.
        rd_rgb_d = image_q[rd_row][rd_col];
    end

    // State registers; reset clears synchronizers, shift data, image and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '0;
            clk_prev_q    <= 1'b0;
            stb_prev_q    <= 1'b0;
            up_sr_q       <= '0;
            lo_sr_q       <= '0;
            bit_cnt_q     <= 6'd0;
            image_q       <= '0;
            rd_rgb_q      <= 3'd0;
            row_latched_q <= 1'b0;
            latched_sel_q <= 4'd0;
            frame_done_q  <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            clk_prev_q    <= clk_prev_d;
            stb_prev_q    <= stb_prev_d;
            up_sr_q       <= up_sr_d;
            lo_sr_q       <= lo_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            image_q       <= image_d;
            rd_rgb_q      <= rd_rgb_d;
            row_latched_q <= row_latched_d;
            latched_sel_q <= latched_sel_d;
            frame_done_q  <= frame_done_d;
            len_err_q     <= len_err_d;
        end
    end

    assign rd_rgb      = rd_rgb_q;
    assign row_latched = row_latched_q;
    assign latched_sel = latched_sel_q;
    assign frame_done  = frame_done_q;
    assign len_err     = len_err_q;
    assign oe_active   = s_oe_on;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: latch events are scoreboarded, image reads are compared
// against constants, a closed-form frame pattern, or a small panel model.
module tb_hub75_rx;
    localparam int COLS = 32;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       R0 = 0, G0 = 0, B0 = 0, R1 = 0, G1 = 0, B1 = 0;
    logic       LED_CLK = 0, STB = 0, OE = 1;
    logic [3:0] sel_ABCD = '0;
    logic [4:0] rd_row = '0, rd_col = '0;
    logic [2:0] rd_rgb;
    logic       row_latched, frame_done, len_err, oe_active;
    logic [3:0] latched_sel;

    hub75_rx #(.COLS(COLS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .LED_CLK(LED_CLK), .STB(STB), .OE(OE), .sel_ABCD(sel_ABCD),
        .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
        .row_latched(row_latched), .latched_sel(latched_sel),
        .frame_done(frame_done), .len_err(len_err), .oe_active(oe_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic       len_err;
        logic       frame_done;
    } lat_t;

    lat_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int latch_cnt = 0;
    int fd_cnt = 0;

    // Panel model: shift registers and image as the bench believes they are.
    logic [2:0] m_up[COLS];
    logic [2:0] m_lo[COLS];
    logic [2:0] m_img[32][32];

    // Scoreboard monitor: every row_latched pulse pops one expected latch.
    always @(negedge clk) begin
        lat_t got, want;
        if (row_latched) begin
            latch_cnt++;
            if (frame_done) fd_cnt++;
            got = {latched_sel, len_err, frame_done};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL latch_unexpected got sel=%0d len_err=%0b frame_done=%0b", latched_sel, len_err, frame_done);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL latch_event got sel=%0d len=%0b fd=%0b want sel=%0d len=%0b fd=%0b",
                             got.sel, got.len_err, got.frame_done, want.sel, want.len_err, want.frame_done);
                end
            end
        end else if (frame_done !== 1'b0 || len_err !== 1'b0) begin
            failures++;
            $display("FAIL stray_pulse frame_done=%0b len_err=%0b without row_latched", frame_done, len_err);
        end
    end

    function automatic logic [2:0] pattern(input int r, input int c);
        logic [4:0] rr;
        logic [4:0] cc;
        rr = 5'(r);
        cc = 5'(c);
        return {rr[0], cc[0], rr[4]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COLS; i++) begin
            m_up[i] = 3'd0;
            m_lo[i] = 3'd0;
        end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) m_img[r][c] = 3'd0;
    endtask

    task automatic model_shift(input logic [2:0] u, input logic [2:0] l);
        for (int i = COLS - 1; i > 0; i--) begin
            m_up[i] = m_up[i-1];
            m_lo[i] = m_lo[i-1];
        end
        m_up[0] = u;
        m_lo[0] = l;
    endtask

    task automatic model_latch(input logic [3:0] sel, input logic exp_len);
        for (int c = 0; c < COLS; c++) begin
            m_img[sel][c]      = m_up[c];
            m_img[sel + 16][c] = m_lo[c];
        end
        exp_q.push_back({sel, exp_len, (sel == 4'hF)});
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One shift clock: data set while LED_CLK is low, 4 clk per phase.
    task automatic drive_bit(input logic [2:0] u, input logic [2:0] l);
        {R0, G0, B0} = u;
        {R1, G1, B1} = l;
        LED_CLK = 1'b0;
        wait_n(4);
        LED_CLK = 1'b1;
        model_shift(u, l);
        wait_n(4);
        LED_CLK = 1'b0;
    endtask

    task automatic latch(input logic [3:0] sel, input logic exp_len);
        sel_ABCD = sel;
        wait_n(2);
        STB = 1'b1;
        model_latch(sel, exp_len);
        wait_n(3);
        STB = 1'b0;
        wait_n(4);
    endtask

    task automatic rd(input int r, input int c, output logic [2:0] v);
        rd_row = 5'(r);
        rd_col = 5'(c);
        @(negedge clk);
        v = rd_rgb;
    endtask

    task automatic test_reset();
        logic [2:0] v;
        int lc0;
        lc0 = latch_cnt;
        sel_ABCD = 4'd9;
        for (int i = 0; i < 5; i++) drive_bit(3'b111, 3'b111);
        LED_CLK = 1'b1;
        #2 reset = 1'b0;
        wait_n(3);
        checks++;
        if ({rd_rgb, row_latched, latched_sel, frame_done, len_err, oe_active} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got rgb=%0d rl=%0b sel=%0d fd=%0b le=%0b oe=%0b want all 0",
                     rd_rgb, row_latched, latched_sel, frame_done, len_err, oe_active);
        end
        LED_CLK = 1'b0;
        STB = 1'b0;
        OE = 1'b1;
        model_clear();
        wait_n(2);
        reset = 1'b1;
        wait_n(8);
        checks++;
        if ({row_latched, latched_sel, frame_done, len_err, oe_active} !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_outputs got rl=%0b sel=%0d fd=%0b le=%0b oe=%0b want all 0",
                     row_latched, latched_sel, frame_done, len_err, oe_active);
        end
        rd(0, 0, v);
        checks++;
        if (v !== 3'd0) begin failures++; $display("FAIL reset_img_0_0 got %b want 000", v); end
        rd(31, 31, v);
        checks++;
        if (v !== 3'd0) begin failures++; $display("FAIL reset_img_31_31 got %b want 000", v); end
        rd(16, 5, v);
        checks++;
        if (v !== 3'd0) begin failures++; $display("FAIL reset_img_16_5 got %b want 000", v); end
        checks++;
        if (latch_cnt != lc0) begin
            failures++;
            $display("FAIL reset_no_latch got %0d latches want 0", latch_cnt - lc0);
        end
    endtask

    task automatic test_single_row();
        logic [2:0] v;
        int lc0;
        lc0 = latch_cnt;
        for (int k = 0; k < COLS; k++)
            drive_bit((k == 0) ? 3'b100 : 3'b000, (k == COLS - 1) ? 3'b011 : 3'b000);
        latch(4'd5, 1'b0);
        checks++;
        if (latch_cnt - lc0 != 1) begin
            failures++;
            $display("FAIL single_row_latches got %0d want 1", latch_cnt - lc0);
        end
        for (int c = 0; c < 32; c++) begin
            rd(5, c, v);
            checks++;
            if (v !== ((c == 31) ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL single_row_upper col=%0d got %b want %b", c, v, (c == 31) ? 3'b100 : 3'b000);
            end
            rd(21, c, v);
            checks++;
            if (v !== ((c == 0) ? 3'b011 : 3'b000)) begin
                failures++;
                $display("FAIL single_row_lower col=%0d got %b want %b", c, v, (c == 0) ? 3'b011 : 3'b000);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [2:0] v;
        int fd0, bad;
        fd0 = fd_cnt;
        for (int s = 0; s < 16; s++) begin
            for (int k = 0; k < COLS; k++)
                drive_bit(pattern(s, 31 - k), pattern(s + 16, 31 - k));
            latch(4'(s), 1'b0);
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            failures++;
            $display("FAIL frame_done_count got %0d want 1", fd_cnt - fd0);
        end
        bad = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                rd(r, c, v);
                checks++;
                if (v !== pattern(r, c)) begin
                    failures++;
                    if (bad < 8) $display("FAIL frame_pixel (%0d,%0d) got %b want %b", r, c, v, pattern(r, c));
                    bad++;
                end
            end
    endtask

    task automatic test_len_err();
        logic [2:0] v;
        for (int k = 0; k < 31; k++) drive_bit(3'(k), 3'(k + 3));
        latch(4'd1, 1'b1);
        for (int k = 0; k < 33; k++) drive_bit(3'(k + 1), 3'(k * 5));
        latch(4'd2, 1'b1);
        for (int k = 0; k < 32; k++) drive_bit(3'(k + 2), 3'(k * 3));
        latch(4'd3, 1'b0);
        // Short row keeps the stale high columns, long row drops the oldest bit.
        for (int c = 0; c < 32; c += 5) begin
            rd(1, c, v);
            checks++;
            if (v !== m_img[1][c]) begin
                failures++;
                $display("FAIL len_short_row col=%0d got %b want %b", c, v, m_img[1][c]);
            end
            rd(18, c, v);
            checks++;
            if (v !== m_img[18][c]) begin
                failures++;
                $display("FAIL len_long_row col=%0d got %b want %b", c, v, m_img[18][c]);
            end
        end
    endtask

    task automatic test_coincident();
        logic [2:0] v;
        for (int k = 0; k < 31; k++) drive_bit(3'b010, 3'b001);
        {R0, G0, B0} = 3'b111;
        {R1, G1, B1} = 3'b101;
        sel_ABCD = 4'd7;
        LED_CLK = 1'b0;
        wait_n(4);
        LED_CLK = 1'b1;
        STB = 1'b1;
        model_shift(3'b111, 3'b101);
        model_latch(4'd7, 1'b0);
        wait_n(4);
        LED_CLK = 1'b0;
        STB = 1'b0;
        wait_n(4);
        rd(7, 0, v);
        checks++;
        if (v !== 3'b111) begin failures++; $display("FAIL coincident_upper_col0 got %b want 111", v); end
        rd(23, 0, v);
        checks++;
        if (v !== 3'b101) begin failures++; $display("FAIL coincident_lower_col0 got %b want 101", v); end
        rd(7, 1, v);
        checks++;
        if (v !== 3'b010) begin failures++; $display("FAIL coincident_upper_col1 got %b want 010", v); end
    endtask

    task automatic test_oe();
        logic [2:0] v;
        int highs;
        logic exp_oe;
        highs = 0;
        OE = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) OE = 1'b1;
            exp_oe = (i >= SYNC && i < SYNC + 10);
            if (oe_active === 1'b1) highs++;
            checks++;
            if (oe_active !== exp_oe) begin
                failures++;
                $display("FAIL oe_active cycle=%0d got %b want %b", i, oe_active, exp_oe);
            end
        end
        checks++;
        if (highs != 10) begin failures++; $display("FAIL oe_high_cycles got %0d want 10", highs); end
        for (int r = 0; r < 32; r += 7) begin
            rd(r, 31 - r, v);
            checks++;
            if (v !== m_img[r][31-r]) begin
                failures++;
                $display("FAIL oe_image_unchanged (%0d,%0d) got %b want %b", r, 31 - r, v, m_img[r][31-r]);
            end
        end
    endtask

    initial begin
        model_clear();
        wait_n(3);
        reset = 1'b1;
        wait_n(3);
        test_reset();
        test_single_row();
        test_full_frame();
        test_len_err();
        test_coincident();
        test_oe();
        test_reset();
        wait_n(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_latches got %0d unconsumed want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
